// File: rtl/cam_line_capture_if.sv
// cam_line_capture_if: camera pins, capture config, pixel stream and status flags
interface cam_line_capture_if #(
  parameter int DATA_W = 8,
  parameter int PIXEL_W = 16,
  parameter int LINE_W = 10
);
  logic p_clk, h_sync, v_sync;
  logic [DATA_W-1:0] i_data;
  logic cfg_swap, cfg_decim;
  logic [PIXEL_W-1:0] o_data;
  logic o_valid, i_ready, o_sof, o_eol;
  logic [LINE_W-1:0] o_line;
  logic o_overflow, o_short_line;
  modport master (
    input p_clk, h_sync, v_sync, i_data, cfg_swap, cfg_decim, i_ready,
    output o_data, o_valid, o_sof, o_eol, o_line, o_overflow, o_short_line
  );
  modport slave (
    output p_clk, h_sync, v_sync, i_data, cfg_swap, cfg_decim, i_ready,
    input o_data, o_valid, o_sof, o_eol, o_line, o_overflow, o_short_line
  );
endinterface

// File: rtl/cam_line_capture.sv
// cam_line_capture: samples a parallel camera bus, packs bytes into pixels and queues them on a valid/ready stream
module cam_line_capture #(
  parameter int DATA_W = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int LINE_PIXELS = 640,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_W = 10
) (
  input logic CLK,
  input logic RST,
  cam_line_capture_if.master bus
);
  localparam int PIXEL_W = DATA_W * BYTES_PER_PIX;
  localparam int PW = $clog2(LINE_PIXELS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = PIXEL_W + LINE_W + 2;
  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [2:0] p_s, h_s, v_s;
  logic [DATA_W-1:0] d_s1, d_s2, d_cur;
  logic p_rise, v_rise, h_fall, h_cur, active;
  logic swap, decim, short_pulse;
  logic [2:0] bcnt;
  logic [PIXEL_W-1:0] pack, pack_nxt, c_data, w_data;
  logic [PW-1:0] pix_cnt;
  logic [LINE_W-1:0] line_cnt, c_line, w_line;
  logic take, done, keep, eol, c_req, c_eol, w_req, w_eol;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic valid, pop, push, sof_armed, overflow;
  always_ff @(posedge CLK)
    if (RST) begin
      p_s <= '0; h_s <= '0; v_s <= '0; d_s1 <= '0; d_s2 <= '0;
      p_rise <= 1'b0; v_rise <= 1'b0; h_fall <= 1'b0; h_cur <= 1'b0; d_cur <= '0;
    end else begin
      p_s <= {p_s[1:0], bus.p_clk};
      h_s <= {h_s[1:0], bus.h_sync};
      v_s <= {v_s[1:0], bus.v_sync};
      d_s1 <= bus.i_data;
      d_s2 <= d_s1;
      p_rise <= p_s[1] & ~p_s[2];
      v_rise <= v_s[1] & ~v_s[2];
      h_fall <= ~h_s[1] & h_s[2];
      h_cur <= h_s[1];
      d_cur <= d_s2;
    end
  always_ff @(posedge CLK) state <= RST ? WAIT_FRAME : state_nxt;
  always_comb state_nxt = v_rise ? ACTIVE : state;
  always_comb active = state == ACTIVE;
  // byte slot depends on arrival order and the byte order latched at frame start
  always_comb begin
    pack_nxt = pack;
    pack_nxt[(swap ? int'(bcnt) : BYTES_PER_PIX - 1 - int'(bcnt)) * DATA_W +: DATA_W] = d_cur;
    take = p_rise & h_cur & active & ~v_rise;
    done = take & (bcnt == 3'(BYTES_PER_PIX - 1));
    keep = done & ~(decim & pix_cnt[0]) & (pix_cnt < PW'(LINE_PIXELS));
    eol = pix_cnt == PW'(decim ? LINE_PIXELS - 2 : LINE_PIXELS - 1);
  end
  always_ff @(posedge CLK)
    if (RST) begin
      swap <= 1'b0; decim <= 1'b0; bcnt <= '0; pack <= '0; pix_cnt <= '0; line_cnt <= '0;
      c_req <= 1'b0; c_eol <= 1'b0; c_data <= '0; c_line <= '0; short_pulse <= 1'b0;
      w_req <= 1'b0; w_eol <= 1'b0; w_data <= '0; w_line <= '0;
    end else begin
      c_req <= keep; c_eol <= eol; c_data <= pack_nxt; c_line <= line_cnt;
      w_req <= c_req; w_eol <= c_eol; w_data <= c_data; w_line <= c_line;
      short_pulse <= h_fall & active & (pix_cnt < PW'(LINE_PIXELS));
      if (v_rise) begin
        swap <= bus.cfg_swap;
        decim <= bus.cfg_decim;
        line_cnt <= '0;
      end else if (h_fall & active) begin
        bcnt <= '0;
        pix_cnt <= '0;
        if (~&line_cnt) line_cnt <= line_cnt + LINE_W'(1);
      end else if (take) begin
        pack <= pack_nxt;
        bcnt <= done ? '0 : bcnt + 3'd1;
        if (done & (pix_cnt < PW'(LINE_PIXELS))) pix_cnt <= pix_cnt + PW'(1);
      end
    end
  always_comb begin
    valid = cnt != '0;
    pop = valid & bus.i_ready;
    push = w_req & ((cnt != (AW+1)'(FIFO_DEPTH)) | pop);
  end
  always_ff @(posedge CLK) if (push) mem[wp] <= {w_data, sof_armed, w_eol, w_line};
  // a dropped pixel leaves sof armed so the frame start survives an overflow
  always_ff @(posedge CLK)
    if (RST) begin
      wp <= '0; rp <= '0; cnt <= '0; sof_armed <= 1'b0; overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      sof_armed <= v_rise | (sof_armed & ~push);
      overflow <= ~v_rise & (overflow | (w_req & ~push));
    end
  assign {bus.o_data, bus.o_sof, bus.o_eol, bus.o_line} = valid ? mem[rp] : '0;
  assign bus.o_valid = valid;
  assign bus.o_overflow = overflow;
  assign bus.o_short_line = short_pulse;
endmodule
